// File: rtl/jaa_arm_decoder.sv
// ---------------------------------------------------------------------------
// jaa_arm_decoder
// Reverses the JAA Java-to-ARM translation. Each legal pair of ARM words is
// collapsed back into the single Java bytecode that produced it.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   arm_instr    ARM word from the translator stream
//   arm_valid    arm_instr valid this cycle
//   arm_ready    decoder accepts a word (transfer = arm_valid & arm_ready)
//   java_opcode  reconstructed Java bytecode, stable while op_valid is high
//   op_valid     java_opcode valid, held until accepted
//   op_ready     sink accepts (transfer = op_valid & op_ready)
//   err          one-cycle pulse: unrecognised first word or illegal pair
//
// Optional build macro JAA_DECODE_STATS_EN adds
//   op_count     16-bit saturating count of transferred opcodes
//   err_count    16-bit saturating count of err pulses
// ---------------------------------------------------------------------------
module jaa_arm_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] arm_instr,
   input  logic        arm_valid,
   output logic        arm_ready,
   output logic [7:0]  java_opcode,
   output logic        op_valid,
   input  logic        op_ready,
   output logic        err
`ifdef JAA_DECODE_STATS_EN
   ,
   output logic [15:0] op_count,
   output logic [15:0] err_count
`endif
);

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_SECOND = 2'd1,
      S_EMIT   = 2'd2
   } state_t;

   // Class of the pending first word; selects which second word is legal.
   typedef enum logic [1:0] {
      C_MOV   = 2'd0,   // MOV r1,#n      -> expects PUSH {r1}
      C_LDR   = 2'd1,   // LDR r3,[r1,#n] -> expects PUSH {r1}
      C_POP1  = 2'd2,   // POP {r1}       -> expects STR r3,[r1,#n]
      C_POP12 = 2'd3    // POP {r1,r2}    -> expects ADD r0,r1,r2
   } cls_t;

   localparam logic [31:0] W_PUSH_R1  = 32'hE92D_0002;
   localparam logic [31:0] W_POP_R1   = 32'hE8BD_0002;
   localparam logic [31:0] W_POP_R12  = 32'hE8BD_0006;
   localparam logic [31:0] W_ADD      = 32'hE081_0002;
   localparam logic [19:0] P_MOV      = 20'hE3A01;
   localparam logic [19:0] P_LDR      = 20'hE5913;
   localparam logic [19:0] P_STR      = 20'hE5813;

   state_t      state_q, state_d;
   cls_t        cls_q, cls_d;
   logic [2:0]  n_q, n_d;
   logic [7:0]  opc_q, opc_d;
   logic        err_q, err_d;

   logic        first_ok_s;
   cls_t        first_cls_s;
   logic [2:0]  first_n_s;
   logic        sec_ok_s;
   logic [7:0]  sec_op_s;

   // Classify the incoming word as a candidate first word. The immediate or
   // offset is compared on its full 12-bit field so e.g. MOV #6 is rejected.
   always_comb begin
      first_ok_s  = 1'b0;
      first_cls_s = C_MOV;
      first_n_s   = 3'd0;
      if ((arm_instr[31:12] == P_MOV) && (arm_instr[11:0] <= 12'd5)) begin
         first_ok_s  = 1'b1;
         first_cls_s = C_MOV;
         first_n_s   = arm_instr[2:0];
      end else if ((arm_instr[31:12] == P_LDR) && (arm_instr[11:0] <= 12'd3)) begin
         first_ok_s  = 1'b1;
         first_cls_s = C_LDR;
         first_n_s   = arm_instr[2:0];
      end else if (arm_instr == W_POP_R1) begin
         first_ok_s  = 1'b1;
         first_cls_s = C_POP1;
      end else if (arm_instr == W_POP_R12) begin
         first_ok_s  = 1'b1;
         first_cls_s = C_POP12;
      end else begin
         first_ok_s  = 1'b0;
      end
   end

   // Check the incoming word against the latched class and form the opcode.
   // For the POP {r1} class the local index comes from the STR offset.
   always_comb begin
      sec_ok_s = 1'b0;
      sec_op_s = 8'h00;
      case (cls_q)
         C_MOV: begin
            if (arm_instr == W_PUSH_R1) begin
               sec_ok_s = 1'b1;
               sec_op_s = 8'h03 + {5'd0, n_q};
            end else begin
               sec_ok_s = 1'b0;
            end
         end
         C_LDR: begin
            if (arm_instr == W_PUSH_R1) begin
               sec_ok_s = 1'b1;
               sec_op_s = 8'h1A + {5'd0, n_q};
            end else begin
               sec_ok_s = 1'b0;
            end
         end
         C_POP1: begin
            if ((arm_instr[31:12] == P_STR) && (arm_instr[11:0] <= 12'd3)) begin
               sec_ok_s = 1'b1;
               sec_op_s = 8'h3B + {6'd0, arm_instr[1:0]};
            end else begin
               sec_ok_s = 1'b0;
            end
         end
         C_POP12: begin
            if (arm_instr == W_ADD) begin
               sec_ok_s = 1'b1;
               sec_op_s = 8'h60;
            end else begin
               sec_ok_s = 1'b0;
            end
         end
         default: begin
            sec_ok_s = 1'b0;
         end
      endcase
   end

   // Next-state logic. A rejected second word is discarded outright rather
   // than being re-examined as a new first word.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      n_d     = n_q;
      opc_d   = opc_q;
      err_d   = 1'b0;
      case (state_q)
         S_FIRST: begin
            if (arm_valid) begin
               if (first_ok_s) begin
                  state_d = S_SECOND;
                  cls_d   = first_cls_s;
                  n_d     = first_n_s;
               end else begin
                  err_d   = 1'b1;
               end
            end else begin
               state_d = S_FIRST;
            end
         end
         S_SECOND: begin
            if (arm_valid) begin
               if (sec_ok_s) begin
                  state_d = S_EMIT;
                  opc_d   = sec_op_s;
               end else begin
                  state_d = S_FIRST;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = S_SECOND;
            end
         end
         S_EMIT: begin
            if (op_ready) begin
               state_d = S_FIRST;
            end else begin
               state_d = S_EMIT;
            end
         end
         default: begin
            state_d = S_FIRST;
         end
      endcase
   end

   // State and datapath registers; reset overrides any handshake in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FIRST;
         cls_q   <= C_MOV;
         n_q     <= 3'd0;
         opc_q   <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         n_q     <= n_d;
         opc_q   <= opc_d;
         err_q   <= err_d;
      end
   end

   assign arm_ready   = (state_q != S_EMIT);
   assign op_valid    = (state_q == S_EMIT);
   assign java_opcode = opc_q;
   assign err         = err_q;

`ifdef JAA_DECODE_STATS_EN
   logic [15:0] op_count_q, err_count_q;

   // Saturating event counters: opcode transfers and err pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count_q  <= 16'h0000;
         err_count_q <= 16'h0000;
      end else begin
         if (op_valid && op_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
         end
         if (err_d && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign op_count  = op_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_jaa_arm_decoder.sv
// Self-checking bench for jaa_arm_decoder: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a table-driven model.
module tb_jaa_arm_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] arm_instr;
   logic        arm_valid;
   logic        arm_ready;
   logic [7:0]  java_opcode;
   logic        op_valid;
   logic        op_ready;
   logic        err;
`ifdef JAA_DECODE_STATS_EN
   logic [15:0] op_count;
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   jaa_arm_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .arm_instr   (arm_instr),
      .arm_valid   (arm_valid),
      .arm_ready   (arm_ready),
      .java_opcode (java_opcode),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .err         (err)
`ifdef JAA_DECODE_STATS_EN
      ,
      .op_count    (op_count),
      .err_count   (err_count)
`endif
   );

   // Table of every legal (first, second) -> opcode pair.
   logic [31:0] t_first [15];
   logic [31:0] t_second[15];
   logic [7:0]  t_op    [15];

   // Model state: at most one pending first word, plus the emit slot.
   logic [31:0] m_pend[$];
   logic        m_emit;
   logic [7:0]  m_op;
   logic        m_err;
   int          m_opc;
   int          m_errc;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit is_first(input logic [31:0] w);
      for (int i = 0; i < 15; i++) if (t_first[i] == w) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pair_op(input logic [31:0] f, input logic [31:0] s);
      for (int i = 0; i < 15; i++)
         if (t_first[i] == f && t_second[i] == s) return int'(t_op[i]);
      return -1;
   endfunction

   function automatic logic [31:0] pick_word();
      int r = $urandom_range(0, 9);
      int k = $urandom_range(0, 14);
      logic [31:0] nm[6];
      nm[0] = 32'hE3A01006; nm[1] = 32'hE5913004; nm[2] = 32'hE5813004;
      nm[3] = 32'hE8BD0004; nm[4] = 32'hE92D0004; nm[5] = 32'hE3A01105;
      if (r <= 3) return t_first[k];
      if (r <= 6) return t_second[k];
      if (r == 7) return nm[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   // One clock: drive inputs, step the model on the edge, compare outputs.
   task automatic cyc(input logic rst, input logic av, input logic [31:0] aw, input logic ordy);
      int p;
      logic [31:0] f;
      reset = rst; arm_valid = av; arm_instr = aw; op_ready = ordy;
      check("arm_ready", {31'd0, arm_ready}, {31'd0, ~m_emit});
      @(posedge clk);
      if (rst) begin
         m_pend.delete(); m_emit = 1'b0; m_op = 8'h00; m_err = 1'b0;
         m_opc = 0; m_errc = 0;
      end else begin
         m_err = 1'b0;
         if (m_emit) begin
            if (ordy) begin
               m_emit = 1'b0;
               if (m_opc < 65535) m_opc++;
            end
         end else if (av) begin
            if (m_pend.size() == 0) begin
               if (is_first(aw)) m_pend.push_back(aw);
               else m_err = 1'b1;
            end else begin
               f = m_pend.pop_front();
               p = pair_op(f, aw);
               if (p >= 0) begin
                  m_op = p[7:0]; m_emit = 1'b1;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
         if (m_err && m_errc < 65535) m_errc++;
      end
      #1;
      check("op_valid", {31'd0, op_valid}, {31'd0, m_emit});
      check("java_opcode", {24'd0, java_opcode}, {24'd0, m_op});
      check("err", {31'd0, err}, {31'd0, m_err});
`ifdef JAA_DECODE_STATS_EN
      check("op_count", {16'd0, op_count}, m_opc);
      check("err_count", {16'd0, err_count}, m_errc);
`endif
   endtask

   initial begin
      for (int n = 0; n < 6; n++) begin
         t_first[n] = 32'hE3A01000 + n; t_second[n] = 32'hE92D0002; t_op[n] = 8'h03 + n;
      end
      for (int n = 0; n < 4; n++) begin
         t_first[6+n]  = 32'hE8BD0002; t_second[6+n]  = 32'hE5813000 + n; t_op[6+n]  = 8'h3B + n;
         t_first[10+n] = 32'hE5913000 + n; t_second[10+n] = 32'hE92D0002; t_op[10+n] = 8'h1A + n;
      end
      t_first[14] = 32'hE8BD0006; t_second[14] = 32'hE0810002; t_op[14] = 8'h60;

      // Reset state
      reset = 1'b1; arm_valid = 1'b0; arm_instr = 32'h0; op_ready = 1'b0;
      @(posedge clk); #1;
      m_emit = 1'b0; m_op = 8'h00; m_err = 1'b0; m_opc = 0; m_errc = 0;
      check("rst_arm_ready", {31'd0, arm_ready}, 32'd1);
      check("rst_op_valid", {31'd0, op_valid}, 32'd0);
      check("rst_opcode", {24'd0, java_opcode}, 32'h00);
      check("rst_err", {31'd0, err}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);

      // iconst_5, op_valid the cycle after the second word
      cyc(1'b0, 1'b1, 32'hE3A01005, 1'b1);
      check("iconst5_not_yet", {31'd0, op_valid}, 32'd0);
      cyc(1'b0, 1'b1, 32'hE92D0002, 1'b1);
      check("iconst5_valid", {31'd0, op_valid}, 32'd1);
      check("iconst5_op", {24'd0, java_opcode}, 32'h08);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);

      // iadd held under back-pressure; words offered meanwhile are ignored
      cyc(1'b0, 1'b1, 32'hE8BD0006, 1'b0);
      cyc(1'b0, 1'b1, 32'hE0810002, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'hE3A01001, 1'b0);
      check("iadd_held", {24'd0, java_opcode}, 32'h60);
      check("iadd_stall_ready", {31'd0, arm_ready}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check("iadd_released", {31'd0, op_valid}, 32'd0);

      // LDR followed by STR: illegal pair, then iload_2
      cyc(1'b0, 1'b1, 32'hE5913002, 1'b1);
      cyc(1'b0, 1'b1, 32'hE5813002, 1'b1);
      check("bad_pair_err", {31'd0, err}, 32'd1);
      check("bad_pair_noop", {31'd0, op_valid}, 32'd0);
      cyc(1'b0, 1'b1, 32'hE5913002, 1'b1);
      check("err_one_cycle", {31'd0, err}, 32'd0);
      cyc(1'b0, 1'b1, 32'hE92D0002, 1'b1);
      check("iload2_op", {24'd0, java_opcode}, 32'h1C);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);

      // MOV #6 rejected as a first word, then istore_3
      cyc(1'b0, 1'b1, 32'hE3A01006, 1'b1);
      check("mov6_err", {31'd0, err}, 32'd1);
      cyc(1'b0, 1'b1, 32'hE8BD0002, 1'b1);
      cyc(1'b0, 1'b1, 32'hE5813003, 1'b1);
      check("istore3_op", {24'd0, java_opcode}, 32'h3E);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);

      // Reset mid-pair drops the half pair silently, then iconst_0
      cyc(1'b0, 1'b1, 32'hE8BD0002, 1'b1);
      cyc(1'b1, 1'b1, 32'hE5813001, 1'b1);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_valid", {31'd0, op_valid}, 32'd0);
      cyc(1'b0, 1'b1, 32'hE3A01000, 1'b1);
      cyc(1'b0, 1'b1, 32'hE92D0002, 1'b0);
      check("iconst0_op", {24'd0, java_opcode}, 32'h03);
      // Reset while an opcode is pending
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      check("emitrst_valid", {31'd0, op_valid}, 32'd0);
      check("emitrst_opcode", {24'd0, java_opcode}, 32'h00);

`ifdef JAA_DECODE_STATS_EN
      // Three legal pairs and two errors from a clean counter state
      cyc(1'b0, 1'b1, 32'hE3A01002, 1'b1); cyc(1'b0, 1'b1, 32'hE92D0002, 1'b1); cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
      cyc(1'b0, 1'b1, 32'hE5913001, 1'b1); cyc(1'b0, 1'b1, 32'hE92D0002, 1'b1); cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'hE8BD0006, 1'b1); cyc(1'b0, 1'b1, 32'hE92D0002, 1'b1);
      cyc(1'b0, 1'b1, 32'hE8BD0006, 1'b1); cyc(1'b0, 1'b1, 32'hE0810002, 1'b1); cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check("stats_op_count", {16'd0, op_count}, 32'd3);
      check("stats_err_count", {16'd0, err_count}, 32'd2);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
             pick_word(), ($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
